// File: rtl/dvp_transmitter_if.sv
// Signal bundle between an AXI4-Stream byte source and the DVP transmitter's parallel video pins.
// A beat transfers on a rising pclk edge where s_axis_tvalid & s_axis_tready are both high; the source holds the beat until then.
interface dvp_transmitter_if;
   logic [7:0] s_axis_tdata;
   logic       s_axis_tvalid;
   logic       s_axis_tready;
   logic       s_axis_tlast;
   logic       s_axis_tuser;
   logic [7:0] dout;
   logic       href_out;
   logic       vsync_out;
   logic       underrun;
   logic       line_err;
   logic       frame_active;

   modport slave (
      input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
      output s_axis_tready, dout, href_out, vsync_out, underrun, line_err, frame_active
   );

   modport master (
      output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
      input  s_axis_tready, dout, href_out, vsync_out, underrun, line_err, frame_active
   );
endinterface

// File: rtl/dvp_transmitter.sv
// Camera emulator: frames an 8-bit AXI4-Stream video stream (TUSER=SOF, TLAST=EOL) into
// registered DVP dout/href/vsync, with all frame and line timing generated from parameters.
module dvp_transmitter #(
   parameter bit         VSYNC_ACTIVE_HIGH = 1'b0,
   parameter bit         HREF_ACTIVE_HIGH  = 1'b1,
   parameter int         H_ACTIVE          = 640,
   parameter int         H_BLANK           = 144,
   parameter int         V_ACTIVE          = 480,
   parameter int         VSYNC_LINES       = 3,
   parameter int         V_BACK_PORCH      = 17,
   parameter int         V_FRONT_PORCH     = 10,
   parameter logic [7:0] PAD_BYTE          = 8'h00
) (
   input  logic             pclk,
   input  logic             resetn,
   dvp_transmitter_if.slave bus,
   output logic [2:0]       dbg_state
);
   localparam int LINE    = H_ACTIVE + H_BLANK;
   localparam int HW      = $clog2(LINE);
   localparam int V_MAX_A = (VSYNC_LINES > V_BACK_PORCH) ? VSYNC_LINES : V_BACK_PORCH;
   localparam int V_MAX_B = (V_ACTIVE > V_FRONT_PORCH) ? V_ACTIVE : V_FRONT_PORCH;
   localparam int V_MAX   = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
   localparam int VW      = (V_MAX > 1) ? $clog2(V_MAX) : 1;

   localparam logic [HW-1:0] H_LAST     = HW'(LINE - 1);
   localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
   localparam logic [VW-1:0] VS_LAST    = VW'(VSYNC_LINES - 1);
   localparam logic [VW-1:0] VBP_LAST   = VW'((V_BACK_PORCH > 0) ? V_BACK_PORCH - 1 : 0);
   localparam logic [VW-1:0] VA_LAST    = VW'(V_ACTIVE - 1);
   localparam logic [VW-1:0] VFP_LAST   = VW'((V_FRONT_PORCH > 0) ? V_FRONT_PORCH - 1 : 0);

   typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBP, S_ACTIVE, S_VFP} state_t;

   state_t        state, state_nx;
   logic [HW-1:0] h_cnt, h_nx;
   logic [VW-1:0] v_cnt, v_nx;
   logic          armed;
   logic          line_done;
   logic          discard;
   logic          sof_pending;
   logic          tready;
   logic          in_slot;
   logic          line_end;
   logic          accept;
   logic [7:0]    dout_q;
   logic          href_q, vsync_q, underrun_q, line_err_q, frame_active_q;

   assign in_slot  = (state == S_ACTIVE) && (h_cnt < H_ACT);
   assign line_end = (h_cnt == H_LAST);
   assign accept   = bus.s_axis_tvalid & tready;

   always_comb begin
      state_nx = state;
      h_nx     = h_cnt;
      v_nx     = v_cnt;
      tready   = 1'b0;
      if (state != S_IDLE) h_nx = line_end ? '0 : h_cnt + 1'b1;
      case (state)
         S_IDLE: begin
            // SOF beat is left on the bus so the first active slot consumes it.
            tready = armed & ~bus.s_axis_tuser;
            if (armed && bus.s_axis_tvalid && bus.s_axis_tuser) begin
               state_nx = S_VSYNC;
               h_nx     = '0;
               v_nx     = '0;
            end
         end
         S_VSYNC: if (line_end) begin
            if (v_cnt == VS_LAST) begin
               v_nx     = '0;
               state_nx = (V_BACK_PORCH == 0) ? S_ACTIVE : S_VBP;
            end else v_nx = v_cnt + 1'b1;
         end
         S_VBP: if (line_end) begin
            if (v_cnt == VBP_LAST) begin
               v_nx     = '0;
               state_nx = S_ACTIVE;
            end else v_nx = v_cnt + 1'b1;
         end
         S_ACTIVE: begin
            tready = in_slot ? ~line_done : discard;
            if (line_end) begin
               if (v_cnt == VA_LAST) begin
                  v_nx     = '0;
                  state_nx = (V_FRONT_PORCH == 0) ? S_IDLE : S_VFP;
               end else v_nx = v_cnt + 1'b1;
            end
         end
         S_VFP: if (line_end) begin
            if (v_cnt == VFP_LAST) begin
               v_nx     = '0;
               state_nx = S_IDLE;
            end else v_nx = v_cnt + 1'b1;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge pclk or negedge resetn) begin
      if (!resetn) begin
         state          <= S_IDLE;
         h_cnt          <= '0;
         v_cnt          <= '0;
         armed          <= 1'b0;
         line_done      <= 1'b0;
         discard        <= 1'b0;
         sof_pending    <= 1'b0;
         dout_q         <= 8'h00;
         href_q         <= ~HREF_ACTIVE_HIGH;
         vsync_q        <= ~VSYNC_ACTIVE_HIGH;
         underrun_q     <= 1'b0;
         line_err_q     <= 1'b0;
         frame_active_q <= 1'b0;
      end else begin
         armed          <= 1'b1;
         state          <= state_nx;
         h_cnt          <= h_nx;
         v_cnt          <= v_nx;
         frame_active_q <= (state != S_IDLE);
         vsync_q        <= VSYNC_ACTIVE_HIGH ? (state == S_VSYNC) : (state != S_VSYNC);
         href_q         <= HREF_ACTIVE_HIGH ? in_slot : ~in_slot;
         underrun_q     <= 1'b0;
         line_err_q     <= 1'b0;
         if (state == S_IDLE && state_nx == S_VSYNC) begin
            line_done   <= 1'b0;
            discard     <= 1'b0;
            sof_pending <= 1'b1;
         end
         if (in_slot) begin
            if (line_done) begin
               dout_q <= PAD_BYTE;
            end else if (!bus.s_axis_tvalid) begin
               dout_q     <= PAD_BYTE;
               underrun_q <= 1'b1;
            end else if (discard) begin
               // Tail of an over-long previous line: drop it, pad the slot.
               dout_q <= PAD_BYTE;
               if (bus.s_axis_tlast) discard <= 1'b0;
            end else begin
               dout_q      <= bus.s_axis_tdata;
               sof_pending <= 1'b0;
               if (bus.s_axis_tuser && !sof_pending) line_err_q <= 1'b1;
               if (bus.s_axis_tlast && h_cnt != H_ACT_LAST) begin
                  line_done  <= 1'b1;
                  line_err_q <= 1'b1;
               end
               if (!bus.s_axis_tlast && h_cnt == H_ACT_LAST) begin
                  discard    <= 1'b1;
                  line_err_q <= 1'b1;
               end
            end
         end else if (state == S_ACTIVE && discard && accept && bus.s_axis_tlast) begin
            discard <= 1'b0;
         end
         if (state == S_ACTIVE && line_end) line_done <= 1'b0;
      end
   end

   assign bus.s_axis_tready = tready;
   assign bus.dout          = dout_q;
   assign bus.href_out      = href_q;
   assign bus.vsync_out     = vsync_q;
   assign bus.underrun      = underrun_q;
   assign bus.line_err      = line_err_q;
   assign bus.frame_active  = frame_active_q;
   assign dbg_state         = state;
endmodule

// File: tb/tb_dvp_transmitter.sv
// Bench for dvp_transmitter: drives frames and compares every pclk of output against a
// slot-by-slot frame model built from the line/frame timing rules.
module tb_dvp_transmitter;
   localparam bit         VAH   = 1'b0;
   localparam bit         HAH   = 1'b1;
   localparam int         H     = 4;
   localparam int         HB    = 2;
   localparam int         VA    = 2;
   localparam int         VS    = 1;
   localparam int         VBP   = 1;
   localparam int         VFP   = 1;
   localparam logic [7:0] PAD   = 8'h00;
   localparam int         LINE  = H + HB;
   localparam int         TOTAL = (VS + VBP + VA + VFP) * LINE;

   logic       pclk = 1'b0;
   logic       resetn = 1'b0;
   logic [2:0] dbg_state;

   dvp_transmitter_if bus();

   dvp_transmitter #(
      .VSYNC_ACTIVE_HIGH(VAH), .HREF_ACTIVE_HIGH(HAH), .H_ACTIVE(H), .H_BLANK(HB),
      .V_ACTIVE(VA), .VSYNC_LINES(VS), .V_BACK_PORCH(VBP), .V_FRONT_PORCH(VFP), .PAD_BYTE(PAD)
   ) dut (
      .pclk(pclk),
      .resetn(resetn),
      .bus(bus),
      .dbg_state(dbg_state)
   );

   always #5 pclk = ~pclk;

   int          checks = 0;
   int          failures = 0;
   logic [9:0]  beat_q[$];          // {tuser, tlast, tdata}
   bit          gap_slot[VA][H];
   logic [12:0] exp_q[$];           // {frame_active, vsync, href, underrun, line_err, dout}
   logic [7:0]  model_dout = 8'h00;

   function automatic logic [12:0] pins(bit fa, bit vs, bit hr, bit ur, bit le, logic [7:0] d);
      return {fa, (VAH ? vs : !vs), (HAH ? hr : !hr), ur, le, d};
   endfunction

   function automatic bit is_gap(int p);
      int ln = p / LINE;
      int hc = p % LINE;
      if (ln >= VS + VBP && ln < VS + VBP + VA && hc < H) return gap_slot[ln - VS - VBP][hc];
      return 1'b0;
   endfunction

   task automatic drive_none();
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tdata  = 8'h00;
      bus.s_axis_tlast  = 1'b0;
      bus.s_axis_tuser  = 1'b0;
   endtask

   task automatic drive_beat(input logic [9:0] b);
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tuser  = b[9];
      bus.s_axis_tlast  = b[8];
      bus.s_axis_tdata  = b[7:0];
   endtask

   task automatic add_beats(input logic [7:0] start, input int n, input bit sof);
      for (int i = 0; i < n; i++)
         beat_q.push_back({(sof && i == 0), (i == n - 1), start + 8'(i)});
   endtask

   task automatic clear_gaps();
      for (int l = 0; l < VA; l++)
         for (int b = 0; b < H; b++) gap_slot[l][b] = 1'b0;
   endtask

   // Walk the frame line by line; each active slot takes the next beat unless the
   // line already ended, the slot is a gap, or an over-long line is being flushed.
   task automatic build_expected();
      logic [9:0] q[$];
      logic [9:0] b;
      logic [7:0] d;
      bit line_done, discard, first, vs, act, slot, ur, le;
      q = beat_q;
      d = model_dout;
      first = 1'b1;
      discard = 1'b0;
      exp_q.delete();
      for (int ln = 0; ln < VS + VBP + VA + VFP; ln++) begin
         line_done = 1'b0;
         for (int hc = 0; hc < LINE; hc++) begin
            vs   = (ln < VS);
            act  = (ln >= VS + VBP) && (ln < VS + VBP + VA);
            slot = act && (hc < H);
            ur   = 1'b0;
            le   = 1'b0;
            if (slot) begin
               if (line_done) d = PAD;
               else if (gap_slot[ln - VS - VBP][hc] || q.size() == 0) begin
                  d  = PAD;
                  ur = 1'b1;
               end else begin
                  b = q.pop_front();
                  if (discard) begin
                     d = PAD;
                     if (b[8]) discard = 1'b0;
                  end else begin
                     d = b[7:0];
                     if (b[9] && !first) le = 1'b1;
                     first = 1'b0;
                     if (b[8] && hc != H - 1) begin line_done = 1'b1; le = 1'b1; end
                     if (!b[8] && hc == H - 1) begin discard = 1'b1; le = 1'b1; end
                  end
               end
            end else if (act && discard && q.size() > 0) begin
               b = q.pop_front();
               if (b[8]) discard = 1'b0;
            end
            exp_q.push_back(pins(1'b1, vs, slot, ur, le, d));
         end
      end
      model_dout = d;
   endtask

   // Runs one frame starting with `junk` non-SOF beats; returns early after position abort_at.
   task automatic run_frame(input int junk, input int abort_at, input string name);
      logic [12:0] act, e;
      logic [7:0]  pre_dout;
      int          waited;
      bit          ok;
      pre_dout = model_dout;
      build_expected();
      for (int k = 0; k < junk; k++) begin
         waited = 0;
         ok = 1'b0;
         while (!ok && waited < 20) begin
            @(negedge pclk);
            drive_beat({2'b00, 8'hA0 + 8'(k)});
            #3;
            checks++;
            if (bus.frame_active !== 1'b0) begin
               failures++;
               $display("FAIL %s idle_frame_active got=%b exp=0", name, bus.frame_active);
            end
            ok = (bus.s_axis_tready === 1'b1);
            waited++;
         end
         checks++;
         if (!ok) begin
            failures++;
            $display("FAIL %s junk_accept beat=%0d got=not_accepted exp=accepted", name, k);
         end
      end
      @(negedge pclk);
      drive_beat(beat_q[0]);
      #3;
      checks++;
      if (bus.s_axis_tready !== 1'b0) begin
         failures++;
         $display("FAIL %s sof_tready got=%b exp=0", name, bus.s_axis_tready);
      end
      for (int j = 0; j <= TOTAL + 1; j++) begin
         @(posedge pclk);
         #1;
         if (j == 0) e = pins(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pre_dout);
         else if (j == TOTAL + 1) e = pins(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, model_dout);
         else e = exp_q[j - 1];
         act = {bus.frame_active, bus.vsync_out, bus.href_out, bus.underrun, bus.line_err, bus.dout};
         checks++;
         if (act !== e) begin
            failures++;
            $display("FAIL %s pos=%0d {fa,vs,href,ur,le,dout} got=%h exp=%h", name, j, act, e);
         end
         if (j == abort_at) return;
         @(negedge pclk);
         if (j < TOTAL && beat_q.size() > 0 && !is_gap(j)) drive_beat(beat_q[0]);
         else drive_none();
         #3;
         if (bus.s_axis_tvalid && bus.s_axis_tready) void'(beat_q.pop_front());
      end
      drive_none();
      beat_q.delete();
   endtask

   task automatic check_reset_pins(input string name);
      logic [12:0] act;
      act = {bus.frame_active, bus.vsync_out, bus.href_out, bus.underrun, bus.line_err, bus.dout};
      checks++;
      if (act !== pins(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00)) begin
         failures++;
         $display("FAIL %s outputs got=%h exp=%h", name, act, pins(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
      end
      checks++;
      if (bus.s_axis_tready !== 1'b0) begin
         failures++;
         $display("FAIL %s tready got=%b exp=0", name, bus.s_axis_tready);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      drive_beat({2'b10, 8'h55});
      #12;
      check_reset_pins("reset");
      checks++;
      if (dbg_state !== 3'd0) begin
         failures++;
         $display("FAIL reset_state got=%0d exp=0", dbg_state);
      end
      @(negedge pclk);
      resetn = 1'b1;
      drive_none();
      @(negedge pclk);
      #1;
      checks++;
      if (bus.s_axis_tready !== 1'b1) begin
         failures++;
         $display("FAIL idle_tready got=%b exp=1", bus.s_axis_tready);
      end
      bus.s_axis_tuser = 1'b1;
      #1;
      checks++;
      if (bus.s_axis_tready !== 1'b0) begin
         failures++;
         $display("FAIL idle_tuser_qualifier got=%b exp=0", bus.s_axis_tready);
      end
      drive_none();
      model_dout = 8'h00;
   endtask

   task automatic test_continuous();
      clear_gaps();
      add_beats(8'h01, 4, 1'b1);
      add_beats(8'h05, 4, 1'b0);
      run_frame(0, -1, "continuous");
   endtask

   task automatic test_pre_sof();
      clear_gaps();
      add_beats(8'h01, 4, 1'b1);
      add_beats(8'h05, 4, 1'b0);
      run_frame(2, -1, "pre_sof");
   endtask

   task automatic test_underrun();
      clear_gaps();
      gap_slot[0][1] = 1'b1;
      add_beats(8'h01, 4, 1'b1);
      add_beats(8'h05, 4, 1'b0);
      run_frame(0, -1, "underrun");
   endtask

   task automatic test_short_line();
      clear_gaps();
      add_beats(8'h01, 2, 1'b1);
      add_beats(8'h03, 4, 1'b0);
      run_frame(0, -1, "short_line");
   endtask

   task automatic test_long_line();
      clear_gaps();
      add_beats(8'h01, 6, 1'b1);
      add_beats(8'h07, 4, 1'b0);
      run_frame(0, -1, "long_line");
   endtask

   task automatic test_reset_mid_frame();
      clear_gaps();
      add_beats(8'h11, 4, 1'b1);
      add_beats(8'h15, 4, 1'b0);
      run_frame(0, (VS + VBP + 1) * LINE + 2, "mid_frame");
      drive_beat({2'b10, 8'h77});
      #2;
      resetn = 1'b0;
      #1;
      check_reset_pins("mid_frame_reset");
      @(negedge pclk);
      resetn = 1'b1;
      drive_none();
      beat_q.delete();
      model_dout = 8'h00;
      clear_gaps();
      add_beats(8'h21, 4, 1'b1);
      add_beats(8'h25, 4, 1'b0);
      run_frame(1, -1, "after_reset");
   endtask

   task automatic test_back_to_back();
      int n;
      for (int f = 0; f < 6; f++) begin
         clear_gaps();
         for (int l = 0; l < VA; l++)
            for (int b = 0; b < H; b++) gap_slot[l][b] = ($urandom_range(0, 99) < 15);
         for (int l = 0; l < VA + 1; l++) begin
            n = $urandom_range(3, 5);
            for (int i = 0; i < n; i++)
               beat_q.push_back({((l == 0 && i == 0) || ($urandom_range(0, 99) < 5)),
                                 (i == n - 1), 8'($urandom_range(1, 255))});
         end
         run_frame($urandom_range(0, 2), -1, "random");
      end
   endtask

   initial begin
      drive_none();
      test_reset();
      test_continuous();
      test_pre_sof();
      test_underrun();
      test_short_line();
      test_long_line();
      test_reset_mid_frame();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
